// File: rtl/weight_pingpong_buffer_if.sv
// Loader, swap and read-port signals of the ping-pong weight buffer.
// The master drives loader/consumer inputs; the slave is the buffer itself.
interface weight_pingpong_buffer_if #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  parameter int DEPTH  = 1024
);
  localparam int AW = $clog2(DEPTH);

  logic                      ld_valid;
  logic                      ld_ready;
  logic [DATA_W-1:0]         ld_data;
  logic                      ld_last;
  logic                      swap_req;
  logic                      rd_en;
  logic [AW-1:0]             rd_addr;
  logic [LANES*DATA_W-1:0]   rd_data;
  logic                      rd_valid;
  logic                      active_bank;
  logic                      active_valid;
  logic [AW:0]               active_words;
  logic                      fill_full;
  logic                      err_overflow;

  modport master (
    output ld_valid, ld_data, ld_last, swap_req, rd_en, rd_addr,
    input  ld_ready, rd_data, rd_valid, active_bank, active_valid,
           active_words, fill_full, err_overflow
  );

  modport slave (
    input  ld_valid, ld_data, ld_last, swap_req, rd_en, rd_addr,
    output ld_ready, rd_data, rd_valid, active_bank, active_valid,
           active_words, fill_full, err_overflow
  );
endinterface

// File: rtl/weight_pingpong_buffer.sv
// Double-banked weight store: a byte loader packs LANES weights per word into
// the fill bank while the consumer reads whole words from the active bank.
module weight_pingpong_buffer #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  parameter int DEPTH  = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  weight_pingpong_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int WW = LANES * DATA_W;
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic {FILL, FULL} state_t;

  state_t            state_q, state_d;
  logic              fill_bank_q, fill_bank_d;
  logic              active_bank_q, active_bank_d;
  logic              active_valid_q, active_valid_d;
  logic [AW:0]       active_words_q, active_words_d;
  logic              pending_q, pending_d;
  logic              err_q, err_d;
  logic [LW-1:0]     lane_q, lane_d;
  logic [AW:0]       wcnt_q, wcnt_d;
  logic              rd_valid_q, rd_valid_d;
  logic [WW-1:0]     rd_data_q, rd_data_d;

  logic [DATA_W-1:0] pack_q [LANES];
  logic [WW-1:0]     mem_q  [2][DEPTH];

  logic              accept;
  logic              wr_en;
  logic              swap;
  logic [WW-1:0]     wr_word;

  // Word image: earlier lanes from the pack register, current byte in place, rest zero
  always_comb begin
    accept  = bus.ld_valid && (state_q == FILL);
    wr_en   = accept && ((lane_q == LW'(LANES - 1)) || bus.ld_last);
    swap    = (state_q == FULL) && (bus.swap_req || pending_q);
    wr_word = '0;
    for (int l = 0; l < LANES; l++) begin
      if (LW'(l) < lane_q)
        wr_word[l*DATA_W +: DATA_W] = pack_q[l];
      else if (LW'(l) == lane_q)
        wr_word[l*DATA_W +: DATA_W] = bus.ld_data;
    end
  end

  always_comb begin
    state_d        = state_q;
    fill_bank_d    = fill_bank_q;
    active_bank_d  = active_bank_q;
    active_valid_d = active_valid_q;
    active_words_d = active_words_q;
    pending_d      = pending_q;
    err_d          = err_q;
    lane_d         = lane_q;
    wcnt_d         = wcnt_q;
    rd_valid_d     = 1'b0;
    rd_data_d      = rd_data_q;

    if (accept) begin
      lane_d = lane_q + LW'(1);
      if (wr_en) begin
        lane_d = '0;
        wcnt_d = wcnt_q + (AW+1)'(1);
        if (bus.ld_last) begin
          state_d = FULL;
        end else if (wcnt_q == (AW+1)'(DEPTH - 1)) begin
          state_d = FULL;
          err_d   = 1'b1;
        end
      end
    end

    // Early requests are remembered and collapse into a single swap
    if (bus.swap_req && (state_q == FILL))
      pending_d = 1'b1;

    if (swap) begin
      active_bank_d  = fill_bank_q;
      fill_bank_d    = ~fill_bank_q;
      active_words_d = wcnt_q;
      active_valid_d = 1'b1;
      pending_d      = 1'b0;
      lane_d         = '0;
      wcnt_d         = '0;
      state_d        = FILL;
    end

    // Reads use the pre-swap active bank, so a read in the swap cycle sees old data
    if (bus.rd_en) begin
      rd_valid_d = active_valid_q;
      if (active_valid_q && ({1'b0, bus.rd_addr} < active_words_q))
        rd_data_d = mem_q[active_bank_q][bus.rd_addr];
      else
        rd_data_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= FILL;
      fill_bank_q    <= 1'b1;
      active_bank_q  <= 1'b0;
      active_valid_q <= 1'b0;
      active_words_q <= '0;
      pending_q      <= 1'b0;
      err_q          <= 1'b0;
      lane_q         <= '0;
      wcnt_q         <= '0;
      rd_valid_q     <= 1'b0;
      rd_data_q      <= '0;
    end else begin
      state_q        <= state_d;
      fill_bank_q    <= fill_bank_d;
      active_bank_q  <= active_bank_d;
      active_valid_q <= active_valid_d;
      active_words_q <= active_words_d;
      pending_q      <= pending_d;
      err_q          <= err_d;
      lane_q         <= lane_d;
      wcnt_q         <= wcnt_d;
      rd_valid_q     <= rd_valid_d;
      rd_data_q      <= rd_data_d;
    end
  end

  // Storage is never cleared; reads beyond the active block are masked instead
  always_ff @(posedge clk) begin
    if (accept && !reset)
      pack_q[lane_q] <= bus.ld_data;
    if (wr_en && !reset)
      mem_q[fill_bank_q][wcnt_q[AW-1:0]] <= wr_word;
  end

  assign bus.ld_ready     = (state_q == FILL);
  assign bus.fill_full    = (state_q == FULL);
  assign bus.rd_data      = rd_data_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.active_bank  = active_bank_q;
  assign bus.active_valid = active_valid_q;
  assign bus.active_words = active_words_q;
  assign bus.err_overflow = err_q;
endmodule

// File: tb/tb_weight_pingpong_buffer.sv
// Directed bench for weight_pingpong_buffer: a DEPTH=1024 instance for the main
// flow and a DEPTH=4 instance for the overflow case.
module tb_weight_pingpong_buffer;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  weight_pingpong_buffer_if #(.DATA_W(8), .LANES(4), .DEPTH(1024)) bus  ();
  weight_pingpong_buffer_if #(.DATA_W(8), .LANES(4), .DEPTH(4))    bus4 ();

  weight_pingpong_buffer #(.DATA_W(8), .LANES(4), .DEPTH(1024)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  weight_pingpong_buffer #(.DATA_W(8), .LANES(4), .DEPTH(4)) dut4 (
    .clk   (clk),
    .reset (rst),
    .bus   (bus4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    bus.ld_valid = 1'b1;
    bus.ld_data  = d;
    bus.ld_last  = last;
    step();
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.ld_valid  = 0; bus.ld_data  = 0; bus.ld_last  = 0; bus.swap_req  = 0;
    bus.rd_en     = 0; bus.rd_addr  = 0;
    bus4.ld_valid = 0; bus4.ld_data = 0; bus4.ld_last = 0; bus4.swap_req = 0;
    bus4.rd_en    = 0; bus4.rd_addr = 0;
    step();
    step();
    rst = 1'b0;

    // 1: reset state and idle read
    repeat (5) step();
    chk("t1_ld_ready",     bus.ld_ready,     1);
    chk("t1_active_valid", bus.active_valid, 0);
    chk("t1_fill_full",    bus.fill_full,    0);
    chk("t1_rd_valid",     bus.rd_valid,     0);
    chk("t1_active_bank",  bus.active_bank,  0);
    chk("t1_err",          bus.err_overflow, 0);
    bus.rd_en = 1; bus.rd_addr = 0;
    step();
    bus.rd_en = 0;
    chk("t1_rd_valid_idle", bus.rd_valid, 0);
    chk("t1_rd_data_idle",  bus.rd_data,  0);

    // 2: 16-byte block into bank 1, swap, read back
    for (int i = 0; i < 16; i++) send(8'((i * 17 + 3) & 8'hFF), i == 15);
    chk("t2_fill_full",    bus.fill_full,    1);
    chk("t2_ld_ready",     bus.ld_ready,     0);
    chk("t2_active_valid", bus.active_valid, 0);
    bus.swap_req = 1;
    step();
    bus.swap_req = 0;
    chk("t2_active_bank",  bus.active_bank,  1);
    chk("t2_active_words", bus.active_words, 4);
    chk("t2_active_valid2", bus.active_valid, 1);
    chk("t2_fill_clear",   bus.fill_full,    0);
    chk("t2_ld_ready2",    bus.ld_ready,     1);
    bus.rd_en = 1; bus.rd_addr = 0;
    step();
    chk("t2_rd0",       bus.rd_data,  32'h36251403);
    chk("t2_rd0_valid", bus.rd_valid, 1);
    bus.rd_addr = 1;
    step();
    chk("t2_rd1", bus.rd_data, 32'h7A695847);
    bus.rd_en = 0;
    step();
    chk("t2_rd_valid_off", bus.rd_valid, 0);
    chk("t2_rd_data_hold", bus.rd_data,  32'h7A695847);

    // 3: load bank 0 while reading bank 1, partial last word zero-padded
    bus.rd_en = 1; bus.rd_addr = 3;
    send(8'h01, 0);
    chk("t3_rd_during_load", bus.rd_data, 32'h02F1E0CF);
    bus.rd_en = 0;
    for (int i = 2; i <= 6; i++) send(8'(i), i == 6);
    chk("t3_fill_full", bus.fill_full, 1);
    bus.swap_req = 1;
    step();
    bus.swap_req = 0;
    chk("t3_active_bank",  bus.active_bank,  0);
    chk("t3_active_words", bus.active_words, 2);
    bus.rd_en = 1; bus.rd_addr = 1;
    step();
    chk("t3_rd1_partial", bus.rd_data, 32'h00000605);
    bus.rd_addr = 2;
    step();
    chk("t3_rd2_oob_data",  bus.rd_data,  0);
    chk("t3_rd2_oob_valid", bus.rd_valid, 1);
    bus.rd_en = 0;

    // 4: early swap request is held until the block completes
    for (int i = 0; i < 3; i++) send(8'(8'h10 + i), 0);
    bus.swap_req = 1;
    step();
    bus.swap_req = 0;
    chk("t4_no_early_swap", bus.active_bank, 0);
    chk("t4_fill_not_full", bus.fill_full,   0);
    for (int i = 3; i < 8; i++) send(8'(8'h10 + i), i == 7);
    chk("t4_full_before_swap", bus.fill_full,   1);
    chk("t4_bank_before_swap", bus.active_bank, 0);
    bus.rd_en = 1; bus.rd_addr = 0;
    step();
    chk("t4_swap_read_old",  bus.rd_data,      32'h04030201);
    chk("t4_swapped_bank",   bus.active_bank,  1);
    chk("t4_swapped_words",  bus.active_words, 2);
    chk("t4_fill_cleared",   bus.fill_full,    0);
    bus.rd_addr = 1;
    step();
    chk("t4_rd_new_bank", bus.rd_data, 32'h17161514);
    bus.rd_en = 0;

    // 5: DEPTH=4 instance overflows after 16 bytes without last
    for (int i = 0; i < 20; i++) begin
      bus4.ld_valid = 1; bus4.ld_data = 8'(8'hA0 + i); bus4.ld_last = 0;
      step();
      if (i == 15) begin
        chk("t5_full_at_16",  bus4.fill_full,    1);
        chk("t5_err_at_16",   bus4.err_overflow, 1);
        chk("t5_ready_at_16", bus4.ld_ready,     0);
      end
    end
    bus4.ld_valid = 0;
    chk("t5_ready_after_20", bus4.ld_ready, 0);
    bus4.swap_req = 1;
    step();
    bus4.swap_req = 0;
    chk("t5_bank",        bus4.active_bank,  1);
    chk("t5_words",       bus4.active_words, 4);
    chk("t5_err_sticky",  bus4.err_overflow, 1);
    chk("t5_fill_clear",  bus4.fill_full,    0);
    bus4.rd_en = 1; bus4.rd_addr = 3;
    step();
    bus4.rd_en = 0;
    chk("t5_rd3", bus4.rd_data, 32'hAFAEADAC);

    // 6: asynchronous reset in the middle of a load and a read
    bus.rd_en = 1; bus.rd_addr = 0;
    send(8'h55, 0);
    chk("t6_rd_before_rst",  bus.rd_data,  32'h13121110);
    chk("t6_vld_before_rst", bus.rd_valid, 1);
    for (int i = 1; i < 5; i++) send(8'(8'h55 + i), 0);
    #1 rst = 1'b1;
    #1;
    chk("t6_async_bank",   bus.active_bank,  0);
    chk("t6_async_valid",  bus.active_valid, 0);
    chk("t6_async_words",  bus.active_words, 0);
    chk("t6_async_rdv",    bus.rd_valid,     0);
    chk("t6_async_rdd",    bus.rd_data,      0);
    chk("t6_async_ready",  bus.ld_ready,     1);
    bus.rd_en = 0;
    step();
    rst = 1'b0;
    step();
    for (int i = 0; i < 4; i++) send(8'(8'hC1 + i), i == 3);
    chk("t6_fresh_full", bus.fill_full, 1);
    bus.swap_req = 1;
    step();
    bus.swap_req = 0;
    chk("t6_fresh_bank",  bus.active_bank,  1);
    chk("t6_fresh_words", bus.active_words, 1);
    bus.rd_en = 1; bus.rd_addr = 0;
    step();
    bus.rd_en = 0;
    chk("t6_fresh_rd0", bus.rd_data, 32'hC4C3C2C1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
